alu_6_bit_scheduler: RTL

Round-robin scheduler that shares one `alu_6_bit` datapath among `NUM_REQ` requesters. It arbitrates requests and screens out invalid opcodes and divide-by-zero. It sequences the ALU's rising-edge `EN` / `BUSY` protocol, captures the one-cycle result window and returns a tagged response to the winning requester. It sits directly between the requester fabric and the ALU instance; nothing else drives the ALU inputs.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/alu_6_bit_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_6_bit datapath and its request scheduler.
package alu_pkg;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned RES_W  = 12;

  localparam logic [DATA_W-1:0] ADD         = 6'd1;
  localparam logic [DATA_W-1:0] SUB         = 6'd2;
  localparam logic [DATA_W-1:0] MUL         = 6'd3;
  localparam logic [DATA_W-1:0] DIV         = 6'd4;
  localparam logic [DATA_W-1:0] AND         = 6'd5;
  localparam logic [DATA_W-1:0] OR          = 6'd6;
  localparam logic [DATA_W-1:0] XOR         = 6'd7;
  localparam logic [DATA_W-1:0] NAND        = 6'd8;
  localparam logic [DATA_W-1:0] NOR         = 6'd9;
  localparam logic [DATA_W-1:0] SHIFT_LEFT  = 6'd10;
  localparam logic [DATA_W-1:0] SHIFT_RIGHT = 6'd11;
  localparam logic [DATA_W-1:0] ROTATE_LEFT = 6'd12;

  localparam logic [DATA_W-1:0] OP_MIN = ADD;
  localparam logic [DATA_W-1:0] OP_MAX = ROTATE_LEFT;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StReject,
    StResp
  } sched_state_e;

  // Opcodes outside the ALU's range and division by zero never reach the ALU.
  function automatic logic op_is_valid(input logic [DATA_W-1:0] opc,
                                       input logic [DATA_W-1:0] opb);
    return (opc >= OP_MIN) && (opc <= OP_MAX) && !((opc == DIV) && (opb == '0));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [NUM_REQ-1:0] REQ_I,
  input  logic               ADVANCE_I,
  output logic               WIN_VALID_O,
  output logic [IdxW-1:0]    WIN_IDX_O
);

  logic [IdxW-1:0] ptr_q;
  int unsigned     cand;
  logic            found;

  always_comb begin
    found     = 1'b0;
    WIN_IDX_O = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && REQ_I[cand[IdxW-1:0]]) begin
        found     = 1'b1;
        WIN_IDX_O = cand[IdxW-1:0];
      end
    end
    WIN_VALID_O = found;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ptr_q <= '0;
    end else if (ADVANCE_I && found) begin
      ptr_q <= (WIN_IDX_O == IdxW'(NUM_REQ - 1)) ? '0 : WIN_IDX_O + IdxW'(1);
    end
  end

endmodule

// File: rtl/alu_6_bit_scheduler.sv
// Shares one alu_6_bit among NUM_REQ requesters: arbitrates, screens bad ops, drives the
// ALU EN/BUSY handshake and returns a one-hot tagged response.
module alu_6_bit_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [NUM_REQ-1:0]        REQ_I,
  input  logic [DATA_W*NUM_REQ-1:0] OPA_I,
  input  logic [DATA_W*NUM_REQ-1:0] OPB_I,
  input  logic [DATA_W*NUM_REQ-1:0] OPC_I,
  output logic [NUM_REQ-1:0]        GNT_O,
  output logic [NUM_REQ-1:0]        RESP_VALID_O,
  output logic [RES_W-1:0]          RESP_DATA_O,
  output logic                      RESP_ERR_O,
  output logic                      SCHED_BUSY_O,
  output logic [DATA_W-1:0]         ALU_DATA_IN_1_O,
  output logic [DATA_W-1:0]         ALU_DATA_IN_2_O,
  output logic [DATA_W-1:0]         ALU_CONTROL_O,
  output logic                      ALU_EN_O,
  input  logic [RES_W-1:0]          ALU_DATA_OUT_I,
  input  logic                      ALU_BUSY_I,
  input  logic                      ALU_DONE_I
);

  localparam int unsigned        IdxW    = $clog2(NUM_REQ);
  localparam int unsigned        CntW    = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  logic                win_valid;
  logic [IdxW-1:0]     win_idx;
  logic [DATA_W-1:0]   win_a, win_b, win_c;
  logic                advance;
  logic                unused_done;

  sched_state_e        state_q;
  logic [NUM_REQ-1:0]  owner_q;
  logic                busy_seen_q;
  logic [CntW-1:0]     cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [RES_W-1:0]    resp_data_q;
  logic                resp_err_q;
  logic                sched_busy_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q, alu_c_q;
  logic                alu_en_q;

  // DONE is also high while the ALU idles, so it cannot mark completion.
  assign unused_done = ALU_DONE_I;

  assign advance = (state_q == StIdle);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .REQ_I      (REQ_I),
    .ADVANCE_I  (advance),
    .WIN_VALID_O(win_valid),
    .WIN_IDX_O  (win_idx)
  );

  assign win_a = OPA_I[DATA_W*win_idx +: DATA_W];
  assign win_b = OPB_I[DATA_W*win_idx +: DATA_W];
  assign win_c = OPC_I[DATA_W*win_idx +: DATA_W];

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      busy_seen_q  <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      sched_busy_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_c_q      <= '0;
      alu_en_q     <= 1'b0;
    end else begin
      gnt_q        <= '0;
      resp_valid_q <= '0;
      alu_en_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            gnt_q        <= OneHot0 << win_idx;
            owner_q      <= OneHot0 << win_idx;
            alu_a_q      <= win_a;
            alu_b_q      <= win_b;
            alu_c_q      <= win_c;
            cnt_q        <= '0;
            sched_busy_q <= 1'b1;
            if (op_is_valid(win_c, win_b)) begin
              alu_en_q <= 1'b1;
              state_q  <= StLaunch;
            end else begin
              state_q  <= StReject;
            end
          end
        end
        StLaunch: begin
          busy_seen_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          if (ALU_BUSY_I) busy_seen_q <= 1'b1;
          // The result is only valid on the first non-busy cycle after busy.
          if (busy_seen_q && !ALU_BUSY_I) begin
            resp_valid_q <= owner_q;
            resp_data_q  <= ALU_DATA_OUT_I;
            resp_err_q   <= 1'b0;
            state_q      <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_valid_q <= owner_q;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StReject: begin
          // Two cycles here so the error response lands two cycles after the grant.
          if (cnt_q == '0) begin
            cnt_q <= CntW'(1);
          end else begin
            resp_valid_q <= owner_q;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          resp_data_q  <= '0;
          resp_err_q   <= 1'b0;
          sched_busy_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign GNT_O           = gnt_q;
  assign RESP_VALID_O    = resp_valid_q;
  assign RESP_DATA_O     = resp_data_q;
  assign RESP_ERR_O      = resp_err_q;
  assign SCHED_BUSY_O    = sched_busy_q;
  assign ALU_DATA_IN_1_O = alu_a_q;
  assign ALU_DATA_IN_2_O = alu_b_q;
  assign ALU_CONTROL_O   = alu_c_q;
  assign ALU_EN_O        = alu_en_q;

endmodule
